// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready command to APB requester with wait-state timeout
module apb_master_bridge #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic psel_n, penable_n, pwrite_n, rsp_valid_n, rsp_write_n, rsp_slverr_n, rsp_timeout_n;
  logic [ADDR_WIDTH-1:0] paddr_n;
  logic [DATA_WIDTH-1:0] pwdata_n, rsp_rdata_n;
  assign cmd_ready = (state == IDLE) && !rsp_valid;
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    psel_n        = psel;
    penable_n     = penable;
    pwrite_n      = pwrite;
    paddr_n       = paddr;
    pwdata_n      = pwdata;
    rsp_valid_n   = rsp_valid && !rsp_ready;
    rsp_write_n   = rsp_write;
    rsp_rdata_n   = rsp_rdata;
    rsp_slverr_n  = rsp_slverr;
    rsp_timeout_n = rsp_timeout;
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        paddr_n   = cmd_addr;
        pwrite_n  = cmd_write;
        pwdata_n  = cmd_write ? cmd_wdata : '0;
        psel_n    = 1'b1;
        penable_n = 1'b0;
        state_n   = SETUP;
      end
      SETUP: begin
        penable_n = 1'b1;
        cnt_n     = '0;
        state_n   = ACCESS;
      end
      ACCESS: if (pready) begin
        psel_n        = 1'b0;
        penable_n     = 1'b0;
        state_n       = IDLE;
        rsp_valid_n   = 1'b1;
        rsp_write_n   = pwrite;
        rsp_slverr_n  = pslverr;
        rsp_rdata_n   = pwrite ? '0 : prdata;
        rsp_timeout_n = 1'b0;
      end else begin
        cnt_n = (&cnt) ? cnt : cnt + 1'b1;
        // abort on the edge that would start the TIMEOUT_CYC+1'th wait cycle
        if (TIMEOUT_CYC != 0 && cnt == LAST) begin
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          state_n       = IDLE;
          rsp_valid_n   = 1'b1;
          rsp_write_n   = pwrite;
          rsp_slverr_n  = 1'b0;
          rsp_rdata_n   = '0;
          rsp_timeout_n = 1'b1;
        end
      end
      default: begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state       <= IDLE;
      cnt         <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      psel        <= psel_n;
      penable     <= penable_n;
      pwrite      <= pwrite_n;
      paddr       <= paddr_n;
      pwdata      <= pwdata_n;
      rsp_valid   <= rsp_valid_n;
      rsp_write   <= rsp_write_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_slverr  <= rsp_slverr_n;
      rsp_timeout <= rsp_timeout_n;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns one response per command.
- Drives the apb_ram slave and future APB peripherals from test sequencers and on-chip controllers.
- Adds a programmable wait-state timeout so a slave that never asserts pready cannot hang the bus.

Parameters:
ADDR_WIDTH, 8, width of paddr and cmd_addr
DATA_WIDTH, 8, width of pwdata, prdata, cmd_wdata and rsp_rdata
TIMEOUT_CYC, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
pclk  input  1  APB clock; all logic on its rising edge
presetn  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted on an edge where valid&ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed on an edge where valid&ready
rsp_write  output  1  echo of the command direction
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_slverr  output  1  pslverr captured at completion
rsp_timeout  output  1  transfer aborted by timeout
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready
pslverr  input  1  APB error; sampled only when pready=1

Behaviour:
- Reset, asynchronous and taking effect immediately, including mid-transfer:
  - state=IDLE.
  - psel, penable, pwrite, paddr and pwdata all 0.
  - rsp_valid, rsp_write, rsp_rdata, rsp_slverr and rsp_timeout all 0.
  - Wait counter 0.
- cmd_ready = (state==IDLE) && !rsp_valid. It is combinational and does not depend on cmd_valid.
- States: IDLE, SETUP, ACCESS.
  - IDLE: on cmd_valid&&cmd_ready, register cmd_addr→paddr, cmd_write→pwrite and cmd_wdata→pwdata (for reads, pwdata is cleared to 0). Then psel=1, penable=0 → SETUP.
  - SETUP: lasts exactly one cycle. penable=1 → ACCESS, counter=0.
  - ACCESS with pready=1 at the edge:
    - Clear psel and penable → IDLE.
    - Set rsp_valid=1 and rsp_write=pwrite.
    - rsp_slverr=pslverr.
    - rsp_rdata = pwrite ? 0 : prdata.
    - rsp_timeout=0.
  - ACCESS with pready=0: counter increments. If TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC-1 at this edge, abort:
    - Clear psel and penable → IDLE.
    - rsp_valid=1, rsp_timeout=1, rsp_slverr=0, rsp_rdata=0.
  - Invalid state encoding → IDLE with the bus deasserted.
- APB rules:
  - paddr, pwrite and pwdata are stable from SETUP through the completing edge.
  - penable is never high without psel.
  - psel drops for at least one cycle between transfers; no back-to-back SETUP.
  - paddr and pwdata hold their last value in IDLE.
- Latency with a zero-wait slave:
  - Accept edge E0, SETUP during E0→E1, ACCESS during E1→E2.
  - rsp_valid is high after E2.
  - Each wait state adds one cycle.
- Response holding:
  - rsp_valid and the rsp_* fields hold until the rsp_ready edge, then rsp_valid=0. The fields may keep their values.
  - Because cmd_ready is low while rsp_valid=1, the earliest next accept is the edge after the response is consumed. Minimum spacing is 4 cycles per transfer at zero wait.
- Counter width: $clog2(TIMEOUT_CYC+1), minimum 1; it saturates and never wraps.
- pslverr and prdata are ignored while pready=0.
- cmd_* inputs may change freely outside the accept edge; they are not re-sampled.

Test Plan:
1. Zero-wait write: cmd addr=0x03, wdata=0xA5, write=1; slave pready tied high.
   - psel high 2 cycles, penable high on cycle 2.
   - rsp_valid after 3 edges with rsp_slverr=0, rsp_rdata=0, rsp_timeout=0.
2. Read-back: read addr=0x03 from the RAM model.
   - rsp_rdata=0xA5, rsp_write=0.
   - paddr constant across SETUP/ACCESS.
3. Wait states: slave holds pready low for 3 ACCESS cycles, then high with prdata=0x5C.
   - penable high 4 cycles.
   - rsp_rdata=0x5C, rsp_timeout=0.
4. Error and timeout:
   - Slave returns pready=1, pslverr=1 → rsp_slverr=1.
   - With TIMEOUT_CYC=4 and pready stuck low → bus released after 4 ACCESS cycles; rsp_timeout=1, rsp_rdata=0.
5. Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 pending.
   - cmd_ready stays 0 and the response fields are stable.
   - Raise rsp_ready → next command is accepted on the following edge.
6. Reset mid-ACCESS: drop presetn while penable=1.
   - psel, penable and rsp_valid go 0 immediately.
   - After release, cmd_ready=1 and a fresh write completes normally.
